// File: rtl/wb_data_ram_pkg.sv
// rtl/wb_data_ram_pkg.sv - shared reset level, zero word, FSM states and lane-mask helper for wb_data_ram
package wb_data_ram_pkg;

    localparam logic        RST_ENABLE  = 1'b0;
    localparam logic        RST_DISABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_data_ram_bank.sv
// rtl/wb_data_ram_bank.sv - one 8-bit byte lane of the data RAM, synchronous read-first port
module data_ram_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_data_ram.sv
// rtl/wb_data_ram.sv - Wishbone-classic data RAM responder; WB_DATA_RAM_ERR_EN turns out-of-range addresses into err
module wb_data_ram
    import wb_data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;
    logic                  addr_err_q;

    logic                  req;
    logic                  in_err;
    logic                  enter_resp;
    logic                  acc_we;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_dat;
    logic [31:0]           rd_word;
    logic                  unused_adr;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_DATA_RAM_ERR_EN
    assign in_err = |wb_adr_i[31:ADDR_WIDTH+2];
`else
    assign in_err = 1'b0;
`endif

    assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i[31:ADDR_WIDTH+2]};

    // With zero wait states the RAM is accessed straight from the bus in IDLE.
    assign acc_we  = (state == ST_IDLE) ? wb_we_i                     : we_q;
    assign acc_err = (state == ST_IDLE) ? in_err                      : addr_err_q;
    assign acc_idx = (state == ST_IDLE) ? wb_adr_i[ADDR_WIDTH+1:2]    : idx_q;
    assign acc_sel = (state == ST_IDLE) ? wb_sel_i                    : sel_q;
    assign acc_dat = (state == ST_IDLE) ? wb_dat_i                    : dat_q;

    always_comb begin
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: enter_resp = req && (WAIT_STATES == 0);
            ST_WAIT: enter_resp = wb_cyc_i && (wait_cnt == 4'd1);
            default: enter_resp = 1'b0;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        data_ram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
            .clk   (clk),
            .we    ((rst != RST_ENABLE) && enter_resp && acc_we && acc_sel[g] && !acc_err),
            .addr  (acc_idx),
            .wdata (acc_dat[g*8 +: 8]),
            .rdata (rd_word[g*8 +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            sel_q      <= 4'h0;
            dat_q      <= ZERO_WORD;
            addr_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q       <= wb_we_i;
                        idx_q      <= wb_adr_i[ADDR_WIDTH+1:2];
                        sel_q      <= wb_sel_i;
                        dat_q      <= wb_dat_i;
                        addr_err_q <= in_err;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == 4'd1) begin
                        state    <= ST_RESP;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wb_ack_o = (state == ST_RESP) && !addr_err_q;
    assign wb_dat_o = ((state == ST_RESP) && !we_q && !addr_err_q) ?
                      (rd_word & lane_mask(sel_q)) : ZERO_WORD;

`ifdef WB_DATA_RAM_ERR_EN
    assign wb_err_o = (state == ST_RESP) && addr_err_q;
`else
    assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_data_ram.sv
// tb/tb_wb_data_ram.sv - directed bench for wb_data_ram at WAIT_STATES 1, 0 and 3
module tb_wb_data_ram;

    logic        clk;
    logic        rst;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [3:0]  sel  [3];
    logic [31:0] wdat [3];
    logic [31:0] rdo  [3];
    logic        ack  [3];
    logic        err  [3];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_data_ram #(
            .ADDR_WIDTH  (10),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wb_cyc_i (cyc[g]),
            .wb_stb_i (stb[g]),
            .wb_we_i  (we[g]),
            .wb_adr_i (adr[g]),
            .wb_sel_i (sel[g]),
            .wb_dat_i (wdat[g]),
            .wb_dat_o (rdo[g]),
            .wb_ack_o (ack[g]),
            .wb_err_o (err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; wdat[k] = d;
    endtask

    task automatic idle(input int k);
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = 32'h0; sel[k] = 4'h0; wdat[k] = 32'h0;
    endtask

    // Full single cycle; lat counts edges from the request edge (=1) to the edge after which ack/err is seen.
    task automatic xfer(input string tag, input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic e);
        @(negedge clk);
        drive(k, w, a, s, d);
        lat = 0; rd = 32'h0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) begin
                lat = i; rd = rdo[k]; e = err[k];
                break;
            end
        end
        idle(k);
        if (lat == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        check({tag, "_ack_end"}, {31'd0, ack[k]}, 32'd0);
        check({tag, "_dat_end"}, rdo[k], 32'h0);
    endtask

    task automatic spacing(input int k, output int sp);
        int first;
        first = 0; sp = 0;
        @(negedge clk);
        drive(k, 1'b0, 32'h10, 4'hF, 32'h0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack[k]) begin
                if (first == 0) first = i;
                else begin
                    sp = i - first;
                    break;
                end
            end
        end
        idle(k);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        e;
    int          sp;

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) idle(k);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        xfer("pre_wr", 0, 1'b1, 32'h40, 4'hF, 32'h55AA55AA, rd, lat, e);

        // Reset held with a live write request: nothing may respond or commit.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b1, 32'h40, 4'hF, 32'h11111111);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("rst_ack", {31'd0, ack[0]}, 32'd0);
            check("rst_dat", rdo[0], 32'h0);
            check("rst_err", {31'd0, err[0]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) idle(k);
        xfer("rst_nowr", 0, 1'b0, 32'h40, 4'hF, 32'h0, rd, lat, e);
        check("rst_nowr_dat", rd, 32'h55AA55AA);

        xfer("wr_full", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat, e);
        check("wr_full_lat", 32'(lat), 32'd2);
        check("wr_full_dat", rd, 32'h0);
        xfer("rd_full", 0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, e);
        check("rd_full_lat", 32'(lat), 32'd2);
        check("rd_full_dat", rd, 32'hDEADBEEF);

        xfer("wr_b0", 0, 1'b1, 32'h10, 4'h1, 32'h000000AA, rd, lat, e);
        xfer("wr_b2", 0, 1'b1, 32'h10, 4'h4, 32'h00CC0000, rd, lat, e);
        xfer("rd_merge", 0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, e);
        check("rd_merge_dat", rd, 32'hDECCBEAA);
        xfer("rd_lo", 0, 1'b0, 32'h13, 4'h3, 32'h0, rd, lat, e);
        check("rd_lo_dat", rd, 32'h0000BEAA);
        xfer("wr_sel0", 0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, rd, lat, e);
        check("wr_sel0_lat", 32'(lat), 32'd2);
        xfer("rd_sel0", 0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, e);
        check("rd_sel0_dat", rd, 32'hDECCBEAA);

        xfer("w0_wr", 1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, rd, lat, e);
        check("w0_wr_lat", 32'(lat), 32'd1);
        xfer("w0_rd", 1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, e);
        check("w0_rd_lat", 32'(lat), 32'd1);
        check("w0_rd_dat", rd, 32'hCAFEF00D);
        xfer("w3_wr", 2, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, rd, lat, e);
        check("w3_wr_lat", 32'(lat), 32'd4);
        xfer("w3_rd", 2, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat, e);
        check("w3_rd_lat", 32'(lat), 32'd4);
        check("w3_rd_dat", rd, 32'h0BADF00D);
        spacing(1, sp);
        check("w0_spacing", 32'(sp), 32'd2);
        spacing(2, sp);
        check("w3_spacing", 32'(sp), 32'd5);

        // Abort a write by dropping cyc two edges into WAIT.
        @(negedge clk);
        drive(2, 1'b1, 32'h20, 4'hF, 32'h12345678);
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_ack_wait", {31'd0, ack[2]}, 32'd0);
        end
        @(negedge clk);
        idle(2);
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_ack_after", {31'd0, ack[2]}, 32'd0);
        end
        xfer("abort_rd", 2, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat, e);
        check("abort_rd_dat", rd, 32'h0BADF00D);

        xfer("w0_init", 0, 1'b1, 32'h0, 4'hF, 32'h01020304, rd, lat, e);
        xfer("hi_wr", 0, 1'b1, 32'h00001000, 4'hF, 32'h77777777, rd, lat, e);
        xfer("hi_rd", 0, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat, e);
`ifdef WB_DATA_RAM_ERR_EN
        check("hi_word0", rd, 32'h01020304);
        xfer("hi_err", 0, 1'b0, 32'h00001000, 4'hF, 32'h0, rd, lat, e);
        check("hi_err_flag", {31'd0, e}, 32'd1);
        check("hi_err_dat", rd, 32'h0);
`else
        check("hi_word0", rd, 32'h77777777);
        xfer("hi_ack", 0, 1'b0, 32'h00001000, 4'hF, 32'h0, rd, lat, e);
        check("hi_ack_flag", {31'd0, e}, 32'd0);
        check("hi_alias_dat", rd, 32'h77777777);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
